// File: rtl/debounce_filter.sv
// Single-bit switch debouncer: sig_o flips once the input has disagreed with it for N enabled samples.
// Latency is N enabled clk edges; enable low freezes all state (no other flow control).
`timescale 1ns/1ps
module debounce_filter #(
  parameter int CLK_PERIOD_ns     = 20,
  parameter int DEBOUNCE_TIMER_ns = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sig_i_sync,
  output logic sig_o
);

  localparam int N_RAW = DEBOUNCE_TIMER_ns / CLK_PERIOD_ns;
  localparam int N     = (N_RAW < 1) ? 1 : N_RAW;
  localparam int CW    = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    RISE_PEND   = 2'b01,
    STABLE_HIGH = 2'b11,
    FALL_PEND   = 2'b10
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;

  // count holds the number of consecutive enabled samples that disagreed with sig_o
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STABLE_LOW;
      count <= '0;
      sig_o <= 1'b0;
    end else begin
      case (state)
        STABLE_LOW: begin
          if (enable && sig_i_sync) begin
            if (N == 1) begin
              state <= STABLE_HIGH;
              sig_o <= 1'b1;
            end else begin
              state <= RISE_PEND;
              count <= CW'(1);
            end
          end
        end

        RISE_PEND: begin
          if (enable) begin
            if (!sig_i_sync) begin
              state <= STABLE_LOW;
              count <= '0;
            end else if (count == LAST) begin
              state <= STABLE_HIGH;
              sig_o <= 1'b1;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        STABLE_HIGH: begin
          if (enable && !sig_i_sync) begin
            if (N == 1) begin
              state <= STABLE_LOW;
              sig_o <= 1'b0;
            end else begin
              state <= FALL_PEND;
              count <= CW'(1);
            end
          end
        end

        FALL_PEND: begin
          if (enable) begin
            if (sig_i_sync) begin
              state <= STABLE_HIGH;
              count <= '0;
            end else if (count == LAST) begin
              state <= STABLE_LOW;
              sig_o <= 1'b0;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        // recovery is unconditional so a corrupted state never waits on enable
        default: begin
          state <= STABLE_LOW;
          count <= '0;
          sig_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: N=10 instance for the main scenarios, N clamped to 1 for the edge case.
`timescale 1ns/1ps
module tb_debounce_filter;

  logic clk;
  logic reset;
  logic enable;
  logic sig_i;
  logic sig_o;
  logic sig_i1;
  logic sig_o1;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_filter #(.CLK_PERIOD_ns(20), .DEBOUNCE_TIMER_ns(200)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sig_i_sync(sig_i), .sig_o(sig_o)
  );

  debounce_filter #(.CLK_PERIOD_ns(20), .DEBOUNCE_TIMER_ns(10)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .sig_i_sync(sig_i1), .sig_o(sig_o1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sig_i  = 1'b1;
    sig_i1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if (sig_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: sig_o=%b expected 0", i, sig_o);
      end
      n_checks++;
      if (sig_o1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold_n1[%0d]: sig_o=%b expected 0", i, sig_o1);
      end
    end
    sig_i  = 1'b0;
    sig_i1 = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: sig_o=%b expected 0", sig_o);
    end
  endtask

  task automatic test_rise();
    longint t0;
    longint dt;
    t0 = $time;
    sig_i = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      n_checks++;
      if (sig_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rise_pending edge %0d: sig_o=%b expected 0", i, sig_o);
      end
    end
    tick(1);
    n_checks++;
    if (sig_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_edge10: sig_o=%b expected 1", sig_o);
    end
    dt = ($time - 1) - t0;
    n_checks++;
    if (dt < 190 || dt > 200) begin
      n_fail++;
      $display("FAIL rise_latency_ns: got %0d expected 190..200", dt);
    end
  endtask

  task automatic test_fall();
    sig_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      n_checks++;
      if (sig_o !== 1'b1) begin
        n_fail++;
        $display("FAIL fall_pending edge %0d: sig_o=%b expected 1", i, sig_o);
      end
    end
    tick(1);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_edge10: sig_o=%b expected 0", sig_o);
    end
    sig_i = 1'b1;
    tick(9);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rerise_edge9: sig_o=%b expected 0", sig_o);
    end
    tick(1);
    n_checks++;
    if (sig_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rerise_edge10: sig_o=%b expected 1", sig_o);
    end
    sig_i = 1'b0;
    tick(10);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_back_low: sig_o=%b expected 0", sig_o);
    end
  endtask

  task automatic test_bounce();
    sig_i = 1'b1;
    tick(6);
    sig_i = 1'b0;
    tick(1);
    sig_i = 1'b1;
    tick(9);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_restart_edge9: sig_o=%b expected 0", sig_o);
    end
    tick(1);
    n_checks++;
    if (sig_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_restart_edge10: sig_o=%b expected 1", sig_o);
    end
    #5 sig_i = 1'b0;
    #1 sig_i = 1'b1;
    tick(12);
    n_checks++;
    if (sig_o !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_high: sig_o=%b expected 1", sig_o);
    end
    sig_i = 1'b0;
    tick(10);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_back_low: sig_o=%b expected 0", sig_o);
    end
    #5 sig_i = 1'b1;
    #1 sig_i = 1'b0;
    tick(12);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_low: sig_o=%b expected 0", sig_o);
    end
  endtask

  task automatic test_enable();
    sig_i = 1'b1;
    tick(5);
    enable = 1'b0;
    tick(2);
    sig_i = 1'b0;
    tick(2);
    sig_i = 1'b1;
    tick(3);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_pause: sig_o=%b expected 0", sig_o);
    end
    enable = 1'b1;
    tick(4);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_resume_edge4: sig_o=%b expected 0", sig_o);
    end
    tick(1);
    n_checks++;
    if (sig_o !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_resume_edge5: sig_o=%b expected 1", sig_o);
    end
    sig_i = 1'b0;
    tick(10);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_back_low: sig_o=%b expected 0", sig_o);
    end
  endtask

  task automatic test_reset_mid();
    sig_i = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(1);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_count: sig_o=%b expected 0", sig_o);
    end
    reset = 1'b0;
    tick(9);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart_edge9: sig_o=%b expected 0", sig_o);
    end
    tick(1);
    n_checks++;
    if (sig_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_restart_edge10: sig_o=%b expected 1", sig_o);
    end
    reset = 1'b1;
    tick(1);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_high: sig_o=%b expected 0", sig_o);
    end
    reset = 1'b0;
    sig_i = 1'b0;
    tick(2);
    n_checks++;
    if (sig_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_high: sig_o=%b expected 0", sig_o);
    end
  endtask

  task automatic test_min_n();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      sig_i1 = pat[i];
      tick(1);
      n_checks++;
      if (sig_o1 !== pat[i]) begin
        n_fail++;
        $display("FAIL n1_follow bit %0d: sig_o=%b expected %b", i, sig_o1, pat[i]);
      end
    end
    enable = 1'b0;
    sig_i1 = 1'b1;
    tick(2);
    n_checks++;
    if (sig_o1 !== 1'b0) begin
      n_fail++;
      $display("FAIL n1_disabled: sig_o=%b expected 0", sig_o1);
    end
    enable = 1'b1;
    tick(1);
    n_checks++;
    if (sig_o1 !== 1'b1) begin
      n_fail++;
      $display("FAIL n1_reenabled: sig_o=%b expected 1", sig_o1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    sig_i  = 1'b0;
    sig_i1 = 1'b0;
    test_reset();
    test_rise();
    test_fall();
    test_bounce();
    test_enable();
    test_reset_mid();
    test_min_n();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_filter.md
# debounce_filter

Single-bit debouncer for mechanical switch and button inputs. The block takes a signal that is already synchronised to `clk` and produces a clean level on `sig_o`. `sig_o` changes only after the input has held the opposite level for a full, parameterised debounce interval. It sits between the input synchroniser and the control logic that consumes button or switch events.

## Interface
- `CLK_PERIOD_ns`, default 20: period of `clk` in ns.
- `DEBOUNCE_TIMER_ns`, default 10_000_000: debounce interval in ns.
- Derived constant N = `DEBOUNCE_TIMER_ns / CLK_PERIOD_ns` (integer floor), forced to a minimum of 1. The counter width is the minimum needed to hold N.

Ports:
- `clk`  in  1  system clock; all logic updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  count enable; when low, all state freezes.
- `sig_i_sync`  in  1  raw input, already synchronised to `clk`.
- `sig_o`  out  1  debounced output level, registered.

## Operation
The FSM has four states, and `sig_o` is a registered state flag:
- STABLE_LOW: `sig_o`=0, count=0.
  - If `sig_i_sync`=1 and `enable`=1, go to RISE_PEND with count=1.
- RISE_PEND: `sig_o`=0.
  - If `sig_i_sync`=0, return to STABLE_LOW and clear count.
  - Otherwise, if `enable`=1, increment count.
  - When count reaches N, go to STABLE_HIGH, set `sig_o`=1 and clear count.
- STABLE_HIGH and FALL_PEND mirror STABLE_LOW and RISE_PEND with polarity inverted; FALL_PEND ends with `sig_o`=0.

Further rules:
- If N=1, STABLE_LOW goes directly to STABLE_HIGH, and STABLE_HIGH directly to STABLE_LOW, on the first differing enabled sample.
- When `enable`=0:
  - state, count and `sig_o` all hold;
  - a bounce seen while disabled does not clear the count.
- A pulse shorter than one clock period that is not sampled at a rising edge has no effect. Any sampled return to the current `sig_o` level restarts the interval from zero.
- Reset:
  - `reset`=1 at a rising edge forces STABLE_LOW, count=0 and `sig_o`=0;
  - reset has priority over `enable` and over the input;
  - reset asserted mid-count discards the pending transition.
- Illegal or unused state encodings recover to STABLE_LOW on the next edge.

## Timing
- Latency: `sig_o` changes on the Nth consecutive enabled rising edge at which `sig_i_sync` differs from `sig_o`.
  - Measured from the input edge, the delay is N×`CLK_PERIOD_ns` plus up to one clock period of sampling alignment.
  - Default parameters: N = 500_000, which gives 10 ms.
  - With `DEBOUNCE_TIMER_ns` = 30_000_000: N = 1_500_000, which gives about 30 ms.
- `sig_o` is a registered output with no combinational path from `sig_i_sync`.
- Rising and falling transitions use the same N. Debouncing is symmetric.
- Cycles with `enable`=0 stretch the latency by exactly the number of disabled cycles.
- After reset deassertion, the first effective sample is at the next rising edge.

## Test plan
All scenarios use `CLK_PERIOD_ns`=20 and `DEBOUNCE_TIMER_ns`=200, so N=10.

1. Reset, then raise `sig_i_sync` and hold it:
   - `sig_o`=0 for 9 edges;
   - `sig_o`=1 after the 10th edge, 190–200 ns from the input edge;
   - `sig_o`=0 throughout reset.
2. Bounce rejection:
   - `sig_i_sync`=1 for 6 edges, 0 for 1 edge, then 1 → `sig_o` rises only 10 edges after the final rise;
   - a 1 ns glitch between clock edges produces no change.
3. Falling debounce: from `sig_o`=1, drop the input and hold it → `sig_o`=0 after exactly 10 edges; then raise it again → `sig_o`=1 after 10 more edges.
4. Enable gating: in RISE_PEND with count=5, drive `enable`=0 for 7 cycles, then 1 → `sig_o` rises 5 enabled edges later, 12 edges after the pause began.
5. Reset mid-operation:
   - assert `reset` for 1 cycle during RISE_PEND, with count=8 and the input still high → `sig_o` stays 0, count restarts, and `sig_o` rises 10 edges after reset is released;
   - assert `reset` in STABLE_HIGH → `sig_o`=0 on that edge.
6. Parameter edge case: `DEBOUNCE_TIMER_ns`=10, so N clamps to 1 → `sig_o` follows `sig_i_sync` with one cycle of latency.
